// File: rtl/sprite_ram_pkg.sv
// Shared types and default geometry for the sprite attribute RAM arbiter.
package sprite_ram_pkg;

    localparam int DEF_AW = 6;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sprite_wbuf.sv
// One-entry posted write buffer for CPU writes into the sprite attribute RAM.
module sprite_wbuf
    import sprite_ram_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] cmp_addr,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          hit
);

    // A load in the same cycle as a drain refills the entry, so valid stays set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            addr <= ld_addr;
            data <= ld_data;
        end
    end

    assign hit = valid && (addr == cmp_addr);

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Shares the single-port sprite RAM between the renderer (always first) and the CPU port.
module sprite_ram_arbiter
    import sprite_ram_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_busy,
    input  logic [AW-1:0] vid_addr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [15:0]   cpu_wait_cnt,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    arb_state_t    state;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_hit;
    logic          wb_drain;
    logic          wb_load;
    logic          rd_grant;
    logic          rd_fwd;
    logic          accept;

    sprite_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .load     (wb_load),
        .drain    (wb_drain),
        .ld_addr  (cpu_addr),
        .ld_data  (cpu_wdata),
        .cmp_addr (cpu_addr),
        .valid    (wb_valid),
        .addr     (wb_addr),
        .data     (wb_data),
        .hit      (wb_hit)
    );

    always_comb begin
        wb_drain = !vid_busy && wb_valid;
        rd_grant = (state == IDLE) && cpu_req && !cpu_we && !vid_busy && !wb_valid;
        rd_fwd   = (state == IDLE) && cpu_req && !cpu_we && wb_hit;
        wb_load  = (state == IDLE) && cpu_req && cpu_we && (!wb_valid || wb_drain);
        accept   = wb_load || rd_fwd || rd_grant;
    end

    // Slot priority: renderer, then buffer drain, then CPU read issue, else park on renderer.
    always_comb begin
        ram_addr = vid_addr;
        ram_we   = 1'b0;
        ram_din  = wb_data;
        if (!vid_busy) begin
            if (wb_valid) begin
                ram_addr = wb_addr;
                ram_we   = 1'b1;
            end else if (rd_grant) begin
                ram_addr = cpu_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cpu_rdata    <= '0;
            cpu_wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_fwd) begin
                        cpu_rdata <= wb_data;
                    end
                    if (accept) begin
                        state <= rd_grant ? RD_WAIT : ACK;
                    end else if (cpu_req) begin
                        cpu_wait_cnt <= sat_inc(cpu_wait_cnt);
                    end
                end
                // RAM latched the read address on the previous edge, so a renderer grab now is harmless.
                RD_WAIT: begin
                    cpu_rdata <= ram_dout;
                    state     <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_ack = (state == ACK);

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Scoreboard bench for sprite_ram_arbiter with a behavioural RAM and architectural memory model.
module tb_sprite_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_busy;
    logic [AW-1:0] vid_addr;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [15:0]   cpu_wait_cnt;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always #5 clk = ~clk;

    sprite_ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .vid_busy     (vid_busy),
        .vid_addr     (vid_addr),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .cpu_wait_cnt (cpu_wait_cnt),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    // Synchronous single-port RAM with 1-cycle read latency, plus a preload path for setup.
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Architectural view seen by the CPU: a write is visible as soon as it is issued.
    logic [DW-1:0] ref_mem [0:63];

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   busy_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat);
        exp_t e;
        e.rd   = !we;
        e.addr = a;
        if (we) begin
            ref_mem[a] = d;
            e.data     = d;
        end else begin
            e.data = ref_mem[a];
        end
        sb.push_back(e);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        lat       = 0;
        forever begin
            @(negedge clk);
            if (cpu_ack) break;
            lat++;
            if (lat > 200) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: got no ack expected ack within 200 cycles, addr %0d", a);
                sb.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every ack and checks renderer pass-through each cycle.
    logic [DW-1:0] last_rd;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            last_rd = '0;
        end else if (cpu_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack expected none at %0t", $time);
            end else begin
                e = sb.pop_front();
                if (e.rd) begin
                    chk("rdata", cpu_rdata, e.data);
                    last_rd = e.data;
                end else begin
                    chk("rdata_hold_on_write", cpu_rdata, last_rd);
                end
            end
        end
        if (vid_busy) begin
            chk("vid_addr_passthru", ram_addr, vid_addr);
            chk("vid_no_write", ram_we, 1'b0);
        end
    end

    initial begin
        int lat;
        int lat2;
        int we_cnt;
        logic [DW-1:0] old20;

        reset     = 1'b0;
        vid_busy  = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;

        for (int i = 0; i < 64; i++) ref_mem[i] = DW'($urandom);
        ref_mem[5] = 16'h1234;
        ref_mem[7] = 16'h7777;

        tick();
        for (int i = 0; i < 64; i++) begin
            pre_we   = 1'b1;
            pre_addr = AW'(i);
            pre_data = ref_mem[i];
            tick();
        end
        pre_we = 1'b0;

        chk("reset_ack", cpu_ack, 1'b0);
        chk("reset_rdata", cpu_rdata, 16'h0);
        chk("reset_wait_cnt", cpu_wait_cnt, 16'h0);
        chk("reset_ram_we", ram_we, 1'b0);
        reset = 1'b1;
        tick();

        // Idle RAM read
        cpu_op(1'b0, 6'd5, '0, lat);
        chk("idle_read_latency", lat, 2);

        // Posted write and forwarded read inside a 72-cycle renderer window
        vid_busy = 1'b1;
        vid_addr = 6'd40;
        cpu_op(1'b1, 6'd3, 16'hBEEF, lat);
        chk("posted_write_latency", lat, 1);
        cpu_op(1'b0, 6'd3, '0, lat);
        chk("forward_read_latency", lat, 1);
        tick(68);
        vid_busy = 1'b0;
        @(negedge clk);
        chk("drain_we", ram_we, 1'b1);
        chk("drain_addr", ram_addr, 6'd3);
        chk("drain_data", ram_din, 16'hBEEF);
        we_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
        end
        chk("single_drain_pulse", we_cnt, 0);
        chk("no_wait_yet", cpu_wait_cnt, 16'd0);
        tick();

        // Back-to-back writes with the renderer holding the slot for five more cycles
        vid_busy = 1'b1;
        cpu_op(1'b1, 6'd10, 16'hA5A5, lat);
        chk("stall_first_latency", lat, 1);
        fork
            cpu_op(1'b1, 6'd11, 16'h5A5A, lat2);
            begin
                tick(5);
                vid_busy = 1'b0;
            end
        join
        chk("stall_second_latency", lat2, 6);
        chk("stall_wait_cnt", cpu_wait_cnt, 16'd5);

        // Renderer grabs the RAM while a granted read is in flight
        fork
            cpu_op(1'b0, 6'd7, '0, lat);
            begin
                tick();
                vid_busy = 1'b1;
                vid_addr = 6'd0;
                @(negedge clk);
                chk("preempt_ram_addr", ram_addr, 6'd0);
                tick(2);
                vid_busy = 1'b0;
            end
        join
        chk("preempt_read_latency", lat, 2);

        // Reset while a posted write is still buffered
        vid_busy = 1'b1;
        old20    = ref_mem[20];
        cpu_op(1'b1, 6'd20, 16'hCAFE, lat);
        chk("buffered_write_latency", lat, 1);
        tick(2);
        #2;
        reset    = 1'b0;
        vid_busy = 1'b0;
        #1;
        chk("midreset_ack", cpu_ack, 1'b0);
        chk("midreset_rdata", cpu_rdata, 16'h0);
        chk("midreset_wait_cnt", cpu_wait_cnt, 16'h0);
        chk("midreset_ram_we", ram_we, 1'b0);
        ref_mem[20] = old20;
        sb.delete();
        tick();
        reset  = 1'b1;
        we_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
        end
        chk("lost_write_no_we", we_cnt, 0);
        tick();

        // Reset while a RAM read is outstanding
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 6'd9;
        @(negedge clk);
        chk("rd_grant_addr", ram_addr, 6'd9);
        @(posedge clk);
        #2;
        reset   = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rdwait_reset_ack", cpu_ack, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(4);
        chk("rdwait_reset_rdata", cpu_rdata, 16'h0);

        // Randomised traffic against a busy renderer
        busy_run = 1'b1;
        fork
            begin
                while (busy_run) begin
                    vid_busy = ($urandom_range(0, 99) < 40);
                    vid_addr = AW'($urandom);
                    tick();
                end
            end
        join_none
        repeat (300) begin
            cpu_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), lat);
            chk("rand_latency_min", (lat >= 1), 1'b1);
            tick($urandom_range(0, 2));
        end
        busy_run = 1'b0;
        tick(2);
        vid_busy = 1'b0;
        tick(3);

        chk("scoreboard_empty", sb.size(), 0);
        for (int i = 0; i < 64; i++) begin
            chk("ram_contents", mem[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
